gate_response_checker: RTL and testbench

//   Self-checking stimulus/response engine for the 3-input dataflow gate block (AND/OR/NAND/NOR).

---
 rtl/gate_response_checker.sv | 173 +++++++++++++++++
 tb/tb_gate_response_checker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_response_checker.sv
// rtl/gate_response_checker.sv - stimulus/response checker for a 3-input AND/OR/NAND/NOR gate block
//
// Walks a,b,c through 000..111, holds each vector SETTLE_CYCLES cycles, then
// compares the four returned gate outputs for one SAMPLE cycle. Reports a
// saturating count of failing vectors, the first failing vector and a sticky
// per-gate mismatch mask.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   start                    run request (honoured in IDLE or DONE only)
//   a_o, b_o, c_o            stimulus to the gate block (vec[2], vec[1], vec[0])
//   and_i, or_i, nand_i, nor_i  responses from the gate block
//   busy, done, pass         run status
//   err_cnt                  failing-vector count, saturating at 2**ERR_W-1
//   first_fail_vec/valid     first mismatching vector of the run
//   fail_mask                sticky mismatch per gate: [0]AND [1]OR [2]NAND [3]NOR
module gate_response_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    output logic             c_o,
    input  logic             and_i,
    input  logic             or_i,
    input  logic             nand_i,
    input  logic             nor_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       first_fail_vec,
    output logic             first_fail_valid,
    output logic [3:0]       fail_mask
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       stim_q, stim_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [2:0]       ffv_q, ffv_d;
    logic             ffval_q, ffval_d;
    logic [3:0]       mask_q, mask_d;

    logic             and_exp;
    logic             or_exp;
    logic [3:0]       mism;

    // Expected gate values are derived from vec_q, which is exactly what the
    // stimulus register is presenting during SETTLE/SAMPLE.
    always_comb begin
        and_exp = &vec_q;
        or_exp  = |vec_q;
        mism    = {nor_i ^ ~or_exp, nand_i ^ ~and_exp, or_i ^ or_exp, and_i ^ and_exp};
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        ffv_d     = ffv_q;
        ffval_d   = ffval_q;
        mask_d    = mask_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = SETTLE;
                    vec_d     = 3'd0;
                    cnt_d     = '0;
                    err_cnt_d = '0;
                    ffv_d     = 3'd0;
                    ffval_d   = 1'b0;
                    mask_d    = 4'b0000;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                // One failing vector counts once regardless of how many gates differ.
                if (mism != 4'b0000) begin
                    if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                    mask_d = mask_q | mism;
                    if (!ffval_q) begin
                        ffval_d = 1'b1;
                        ffv_d   = vec_q;
                    end
                end
                if (vec_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 3'd1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status and stimulus are registered from the next state so they line
        // up with the state they describe.
        busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_cnt_d == '0);
        stim_d = busy_d ? vec_d : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vec_q     <= 3'd0;
            cnt_q     <= '0;
            stim_q    <= 3'b000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= '0;
            ffv_q     <= 3'd0;
            ffval_q   <= 1'b0;
            mask_q    <= 4'b0000;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            stim_q    <= stim_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_cnt_q <= err_cnt_d;
            ffv_q     <= ffv_d;
            ffval_q   <= ffval_d;
            mask_q    <= mask_d;
        end
    end

    assign a_o              = stim_q[2];
    assign b_o              = stim_q[1];
    assign c_o              = stim_q[0];
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_cnt          = err_cnt_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffval_q;
    assign fail_mask        = mask_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// tb/tb_gate_response_checker.sv - self-checking bench for gate_response_checker
module tb_gate_response_checker;

    logic clk = 1'b0;
    logic rst_n;
    logic start, start3;
    int   fault;

    logic a_o, b_o, c_o, and_i, or_i, nand_i, nor_i;
    logic busy, done, pass, ffval;
    logic [3:0] err_cnt, mask;
    logic [2:0] ffv;

    logic a3, b3, c3, and3, or3, nand3, nor3;
    logic busy3, done3, pass3, ffval3;
    logic [2:0] err_cnt3, ffv3;
    logic [3:0] mask3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       pass;
        logic [3:0] err;
        logic       valid;
        logic [2:0] vec;
        logic [3:0] mask;
    } result_t;

    result_t    res_q[$];
    logic [2:0] walk_q[$];

    always #5 clk = ~clk;

    gate_response_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_o(a_o), .b_o(b_o), .c_o(c_o),
        .and_i(and_i), .or_i(or_i), .nand_i(nand_i), .nor_i(nor_i),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_fail_vec(ffv), .first_fail_valid(ffval), .fail_mask(mask)
    );

    gate_response_checker #(.SETTLE_CYCLES(2), .ERR_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .a_o(a3), .b_o(b3), .c_o(c3),
        .and_i(and3), .or_i(or3), .nand_i(nand3), .nor_i(nor3),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err_cnt3),
        .first_fail_vec(ffv3), .first_fail_valid(ffval3), .fail_mask(mask3)
    );

    // Gate block models: fault 0 good, 1 AND stuck at 0, 2 OR inverted.
    always_comb begin
        and_i  = a_o & b_o & c_o;
        or_i   = a_o | b_o | c_o;
        nand_i = ~(a_o & b_o & c_o);
        nor_i  = ~(a_o | b_o | c_o);
        if (fault == 1) and_i = 1'b0;
        if (fault == 2) or_i  = ~(a_o | b_o | c_o);
    end

    // Second instance always sees an inverted NOR.
    always_comb begin
        and3  = a3 & b3 & c3;
        or3   = a3 | b3 | c3;
        nand3 = ~(a3 & b3 & c3);
        nor3  = a3 | b3 | c3;
    end

    function automatic result_t model(input int f, input int errmax);
        result_t    r;
        logic [3:0] e, g, mm;
        logic [2:0] vv;
        int         cnt = 0;
        r.valid = 1'b0;
        r.vec   = 3'd0;
        r.mask  = 4'b0000;
        for (int v = 0; v < 8; v++) begin
            vv = 3'(v);
            e = {~(vv[2] | vv[1] | vv[0]), ~(vv[2] & vv[1] & vv[0]),
                 vv[2] | vv[1] | vv[0], vv[2] & vv[1] & vv[0]};
            g = e;
            if (f == 1) g[0] = 1'b0;
            if (f == 2) g[1] = ~g[1];
            if (f == 3) g[3] = ~g[3];
            mm = g ^ e;
            if (mm != 4'b0000) begin
                if (cnt < errmax) cnt++;
                if (!r.valid) begin
                    r.valid = 1'b1;
                    r.vec   = vv;
                end
                r.mask = r.mask | mm;
            end
        end
        r.err  = 4'(cnt);
        r.pass = (cnt == 0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input result_t r);
        chk("done", done, 1);
        chk("busy_in_done", busy, 0);
        chk("stim_in_done", {a_o, b_o, c_o}, 0);
        chk("pass", pass, r.pass);
        chk("err_cnt", err_cnt, r.err);
        chk("first_fail_valid", ffval, r.valid);
        if (r.valid) chk("first_fail_vec", ffv, r.vec);
        chk("fail_mask", mask, r.mask);
    endtask

    // One full run on the main instance; the walk and latency are checked every cycle.
    task automatic run(input int f, input bit hold, input int repulse_at);
        logic [2:0] w;
        fault = f;
        res_q.push_back(model(f, 15));
        @(negedge clk);
        start = 1'b1;
        for (int v = 0; v < 8; v++)
            for (int k = 0; k < 3; k++) walk_q.push_back(3'(v));
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == repulse_at) start = 1'b1;
            else if (!hold) start = 1'b0;
            w = walk_q.pop_front();
            chk("walk_busy_done_stim", {busy, done, a_o, b_o, c_o}, {1'b1, 1'b0, w});
            @(negedge clk);
        end
        check_result(res_q.pop_front());
        if (hold) begin
            res_q.push_back(model(f, 15));
            @(negedge clk);
            start = 1'b0;
            chk("held_start_restart", {busy, done}, 2'b10);
            repeat (24) @(negedge clk);
            check_result(res_q.pop_front());
        end
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        start  = 1'b0;
        start3 = 1'b0;
        fault  = 0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {busy, done, pass, err_cnt, ffv, ffval, mask, a_o, b_o, c_o}, 0);
        chk("reset_outputs3", {busy3, done3, pass3, err_cnt3, ffv3, ffval3, mask3, a3, b3, c3}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", {busy, done, a_o, b_o, c_o}, 0);

        // Good model, single start pulse.
        run(0, 1'b0, -1);

        // done is a level and stimulus stays 000 in DONE.
        repeat (3) @(negedge clk);
        chk("done_held", {done, pass, busy, a_o, b_o, c_o}, 6'b110000);

        // AND stuck at 0: only vector 7 fails.
        run(1, 1'b0, -1);

        // OR inverted, start re-pulsed mid-run must be ignored.
        run(2, 1'b0, 10);

        // New start from DONE clears the failing results.
        run(0, 1'b0, -1);

        // Start held through DONE restarts one cycle after done rises.
        run(0, 1'b1, -1);

        // NOR inverted on the ERR_W=3 instance: counter saturates at 7.
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        n = 0;
        while (!done3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency3", n, 24);
        chk("err_cnt3_sat", err_cnt3, 7);
        chk("first_fail3", {ffval3, ffv3}, 4'b1000);
        chk("fail_mask3", mask3, 4'b1000);
        chk("pass3", pass3, 0);

        // Reset during vector 4 of a failing run leaves no residue.
        fault = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while ({a_o, b_o, c_o} != 3'b100 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("reached_vec4", {a_o, b_o, c_o}, 3'b100);
        chk("err_before_reset", err_cnt, 4);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrun_reset", {busy, done, pass, err_cnt, ffv, ffval, mask, a_o, b_o, c_o}, 0);
        chk("midrun_reset3", {busy3, done3, pass3, err_cnt3, ffv3, ffval3, mask3}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {busy, done, pass, err_cnt, ffv, ffval, mask, a_o, b_o, c_o}, 0);
        run(0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
